// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM of the multicycle RV32I core.
// Sequences fetch, decode, address generation, memory access, execute and
// writeback over several cycles. It drives the datapath mux selects, the
// extend-unit immediate type, the ALU operation and the write enables.
// Optional build macro MULTICYCLE_CTRL_TRAP_EN: an unknown opcode parks the
// FSM in TRAP and raises o_illegal_instr. Without it, an unknown opcode is
// treated as a NOP.
//
// state     | enc | meaning
// ----------+-----+------------------------------------------------------
// FETCH     |  0  | read instruction at PC, PC <= PC + 4 on mem_ready
// DECODE    |  1  | read registers, ALUOut <= OldPC + imm (branch target)
// MEMADR    |  2  | ALUOut <= rs1 + imm (load/store address)
// MEMREAD   |  3  | read data memory at ALUOut
// MEMWB     |  4  | rd <= loaded data
// MEMWRITE  |  5  | write rs2 to memory at ALUOut
// EXECUTER  |  6  | ALUOut <= rs1 op rs2
// ALUWB     |  7  | rd <= ALUOut
// EXECUTEI  |  8  | ALUOut <= rs1 op imm
// JAL       |  9  | PC <= branch target, ALUOut <= OldPC + 4
// BEQ       | 10  | compare rs1/rs2, PC <= target when equal
// LUI       | 11  | ALUOut <= 0 + U-immediate
// TRAP      | 15  | illegal opcode, held until reset (macro builds only)

module multicycle_ctrl #(
  parameter bit SINGLE_CYCLE_MEM = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [6:0] i_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_zero,
  input  logic       i_mem_ready,
  output logic       o_mem_req,
  output logic       o_mem_write,
  output logic       o_adr_src,
  output logic       o_ir_write,
  output logic       o_pc_write,
  output logic       o_reg_write,
  output logic [1:0] o_result_src,
  output logic [1:0] o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [2:0] o_imm_src,
  output logic [2:0] o_alu_control,
`ifdef MULTICYCLE_CTRL_TRAP_EN
  output logic       o_illegal_instr,
`endif
  output logic [3:0] o_state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_LUI      = 4'd11,
    S_TRAP     = 4'd15
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_SUB   = 2'd1,
    ALUOP_FUNCT = 2'd2
  } aluop_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  state_t     r_state;
  state_t     w_next;
  aluop_t     w_aluop;
  logic       w_mem_ready;
  logic       w_mem_req;
  logic       w_mem_write;
  logic       w_adr_src;
  logic       w_ir_write;
  logic       w_pc_update;
  logic       w_branch;
  logic       w_reg_write;
  logic [1:0] w_result_src;
  logic [1:0] w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [2:0] w_imm_src;
  logic [2:0] w_alu_control;
  logic       w_illegal;

  // With single-cycle memory every access completes in the cycle it is issued.
  assign w_mem_ready = SINGLE_CYCLE_MEM ? 1'b1 : i_mem_ready;

  // State register; reset aborts any instruction in flight and restarts at FETCH.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic and Moore outputs per state (FETCH strobes gated by ready).
  always_comb begin
    w_next       = r_state;
    w_aluop      = ALUOP_ADD;
    w_mem_req    = 1'b0;
    w_mem_write  = 1'b0;
    w_adr_src    = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_update  = 1'b0;
    w_branch     = 1'b0;
    w_reg_write  = 1'b0;
    w_result_src = 2'b00;
    w_alu_src_a  = 2'b00;
    w_alu_src_b  = 2'b00;
    w_illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_req    = 1'b1;
        w_alu_src_b  = 2'b10;
        w_result_src = 2'b10;
        w_ir_write   = w_mem_ready;
        w_pc_update  = w_mem_ready;
        if (w_mem_ready) begin
          w_next = S_DECODE;
        end
      end
      S_DECODE: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b01;
        case (i_op)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_RTYPE:          w_next = S_EXECUTER;
          OP_IALU:           w_next = S_EXECUTEI;
          OP_BRANCH:         w_next = S_BEQ;
          OP_JAL:            w_next = S_JAL;
          OP_LUI:            w_next = S_LUI;
`ifdef MULTICYCLE_CTRL_TRAP_EN
          default:           w_next = S_TRAP;
`else
          default:           w_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        w_next      = i_op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        w_mem_req = 1'b1;
        w_adr_src = 1'b1;
        if (w_mem_ready) begin
          w_next = S_MEMWB;
        end
      end
      S_MEMWB: begin
        w_result_src = 2'b01;
        w_reg_write  = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEMWRITE: begin
        w_mem_req   = 1'b1;
        w_mem_write = 1'b1;
        w_adr_src   = 1'b1;
        if (w_mem_ready) begin
          w_next = S_FETCH;
        end
      end
      S_EXECUTER: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b00;
        w_aluop     = ALUOP_FUNCT;
        w_next      = S_ALUWB;
      end
      S_ALUWB: begin
        w_result_src = 2'b00;
        w_reg_write  = 1'b1;
        w_next       = S_FETCH;
      end
      S_EXECUTEI: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        w_aluop     = ALUOP_FUNCT;
        w_next      = S_ALUWB;
      end
      S_JAL: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b10;
        w_pc_update = 1'b1;
        w_next      = S_ALUWB;
      end
      S_BEQ: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b00;
        w_aluop     = ALUOP_SUB;
        w_branch    = 1'b1;
        w_next      = S_FETCH;
      end
      S_LUI: begin
        w_alu_src_a = 2'b11;
        w_alu_src_b = 2'b01;
        w_next      = S_ALUWB;
      end
`ifdef MULTICYCLE_CTRL_TRAP_EN
      S_TRAP: begin
        w_illegal = 1'b1;
        w_next    = S_TRAP;
      end
`endif
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  // ALU control: fixed add/sub, or operation chosen by funct3 for R/I-type.
  always_comb begin
    w_alu_control = 3'b000;
    case (w_aluop)
      ALUOP_ADD: w_alu_control = 3'b000;
      ALUOP_SUB: w_alu_control = 3'b001;
      ALUOP_FUNCT: begin
        case (i_funct3)
          3'b000:  w_alu_control = (i_op[5] & i_funct7b5) ? 3'b001 : 3'b000;
          3'b010:  w_alu_control = 3'b101;
          3'b110:  w_alu_control = 3'b011;
          3'b111:  w_alu_control = 3'b010;
          default: w_alu_control = 3'b000;
        endcase
      end
      default: w_alu_control = 3'b000;
    endcase
  end

  // Immediate type follows the opcode in every state; unknown opcodes give I-type.
  always_comb begin
    w_imm_src = 3'b000;
    case (i_op)
      OP_STORE:  w_imm_src = 3'b001;
      OP_BRANCH: w_imm_src = 3'b010;
      OP_JAL:    w_imm_src = 3'b011;
      OP_LUI:    w_imm_src = 3'b100;
      default:   w_imm_src = 3'b000;
    endcase
  end

  // Write enables and memory request are held off for the whole reset window.
  assign o_mem_req     = w_mem_req   & ~i_reset;
  assign o_mem_write   = w_mem_write & ~i_reset;
  assign o_ir_write    = w_ir_write  & ~i_reset;
  assign o_reg_write   = w_reg_write & ~i_reset;
  assign o_pc_write    = (w_pc_update | (w_branch & i_zero)) & ~i_reset;
  assign o_adr_src     = w_adr_src;
  assign o_result_src  = w_result_src;
  assign o_alu_src_a   = w_alu_src_a;
  assign o_alu_src_b   = w_alu_src_b;
  assign o_imm_src     = w_imm_src;
  assign o_alu_control = w_alu_control;
  assign o_state       = r_state;
`ifdef MULTICYCLE_CTRL_TRAP_EN
  assign o_illegal_instr = w_illegal;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: cycle-by-cycle vector table for the control FSM plus
// hand-written sequences for reset abort and the illegal-opcode path.
`timescale 1ns/1ps

module tb_multicycle_ctrl;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_write;
  logic       adr_src;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] imm_src;
  logic [2:0] alu_control;
  logic [3:0] state;
`ifdef MULTICYCLE_CTRL_TRAP_EN
  logic       illegal_instr;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RT   = 7'b0110011;
  localparam logic [6:0] IA   = 7'b0010011;
  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] LUI  = 7'b0110111;
  localparam logic [6:0] BAD  = 7'h7F;

  multicycle_ctrl dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_op          (op),
    .i_funct3      (funct3),
    .i_funct7b5    (funct7b5),
    .i_zero        (zero),
    .i_mem_ready   (mem_ready),
    .o_mem_req     (mem_req),
    .o_mem_write   (mem_write),
    .o_adr_src     (adr_src),
    .o_ir_write    (ir_write),
    .o_pc_write    (pc_write),
    .o_reg_write   (reg_write),
    .o_result_src  (result_src),
    .o_alu_src_a   (alu_src_a),
    .o_alu_src_b   (alu_src_b),
    .o_imm_src     (imm_src),
    .o_alu_control (alu_control),
`ifdef MULTICYCLE_CTRL_TRAP_EN
    .o_illegal_instr (illegal_instr),
`endif
    .o_state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        z;
    logic        rdy;
    logic [21:0] exp;
  } vec_t;

  vec_t tbl[$];

  // Packed expectation: state, req, mw, adr, irw, pcw, rw, rs, a, b, imm, alu.
  function automatic logic [21:0] ex(input int st, input int req, input int mw,
                                     input int adr, input int irw, input int pcw,
                                     input int rw, input int rs, input int a,
                                     input int b, input int imm, input int alu);
    ex = {st[3:0], req[0], mw[0], adr[0], irw[0], pcw[0], rw[0],
          rs[1:0], a[1:0], b[1:0], imm[2:0], alu[2:0]};
  endfunction

  task automatic add(input logic [6:0] o, input int f3, input int f7, input int z,
                     input int rdy, input logic [21:0] e);
    vec_t v;
    v.op = o; v.f3 = f3[2:0]; v.f7 = f7[0]; v.z = z[0]; v.rdy = rdy[0]; v.exp = e;
    tbl.push_back(v);
  endtask

  function automatic logic [21:0] actual();
    actual = {state, mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
              result_src, alu_src_a, alu_src_b, imm_src, alu_control};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic drive(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input logic z, input logic rdy);
    op = o; funct3 = f3; funct7b5 = f7; zero = z; mem_ready = rdy;
  endtask

  initial begin
    reset = 1'b1;
    drive(7'd0, 3'd0, 1'b0, 1'b0, 1'b1);

    // lw, zero-wait: 0,1,2,3,4
    add(LW,2,0,0,1, ex(0,1,0,0,1,1,0,2,0,2,0,0));
    add(LW,2,0,0,1, ex(1,0,0,0,0,0,0,0,1,1,0,0));
    add(LW,2,0,0,1, ex(2,0,0,0,0,0,0,0,2,1,0,0));
    add(LW,2,0,0,1, ex(3,1,0,1,0,0,0,0,0,0,0,0));
    add(LW,2,0,0,1, ex(4,0,0,0,0,0,1,1,0,0,0,0));
    // sw: one fetch stall, then three MEMWRITE stalls
    add(SW,2,0,0,0, ex(0,1,0,0,0,0,0,2,0,2,1,0));
    add(SW,2,0,0,1, ex(0,1,0,0,1,1,0,2,0,2,1,0));
    add(SW,2,0,0,1, ex(1,0,0,0,0,0,0,0,1,1,1,0));
    add(SW,2,0,0,1, ex(2,0,0,0,0,0,0,0,2,1,1,0));
    add(SW,2,0,0,0, ex(5,1,1,1,0,0,0,0,0,0,1,0));
    add(SW,2,0,0,0, ex(5,1,1,1,0,0,0,0,0,0,1,0));
    add(SW,2,0,0,0, ex(5,1,1,1,0,0,0,0,0,0,1,0));
    add(SW,2,0,0,1, ex(5,1,1,1,0,0,0,0,0,0,1,0));
    // R-type sub
    add(RT,0,1,0,1, ex(0,1,0,0,1,1,0,2,0,2,0,0));
    add(RT,0,1,0,1, ex(1,0,0,0,0,0,0,0,1,1,0,0));
    add(RT,0,1,0,1, ex(6,0,0,0,0,0,0,0,2,0,0,1));
    add(RT,0,1,0,1, ex(7,0,0,0,0,0,1,0,0,0,0,0));
    // R-type and, then slt (EXECUTER only differs in alu)
    add(RT,7,0,0,1, ex(0,1,0,0,1,1,0,2,0,2,0,0));
    add(RT,7,0,0,1, ex(1,0,0,0,0,0,0,0,1,1,0,0));
    add(RT,7,0,0,1, ex(6,0,0,0,0,0,0,0,2,0,0,2));
    add(RT,7,0,0,1, ex(7,0,0,0,0,0,1,0,0,0,0,0));
    add(RT,2,0,0,1, ex(0,1,0,0,1,1,0,2,0,2,0,0));
    add(RT,2,0,0,1, ex(1,0,0,0,0,0,0,0,1,1,0,0));
    add(RT,2,0,0,1, ex(6,0,0,0,0,0,0,0,2,0,0,5));
    add(RT,2,0,0,1, ex(7,0,0,0,0,0,1,0,0,0,0,0));
    // addi with funct7b5=1 must stay add
    add(IA,0,1,0,1, ex(0,1,0,0,1,1,0,2,0,2,0,0));
    add(IA,0,1,0,1, ex(1,0,0,0,0,0,0,0,1,1,0,0));
    add(IA,0,1,0,1, ex(8,0,0,0,0,0,0,0,2,1,0,0));
    add(IA,0,1,0,1, ex(7,0,0,0,0,0,1,0,0,0,0,0));
    // ori
    add(IA,6,0,0,1, ex(0,1,0,0,1,1,0,2,0,2,0,0));
    add(IA,6,0,0,1, ex(1,0,0,0,0,0,0,0,1,1,0,0));
    add(IA,6,0,0,1, ex(8,0,0,0,0,0,0,0,2,1,0,3));
    add(IA,6,0,0,1, ex(7,0,0,0,0,0,1,0,0,0,0,0));
    // beq taken
    add(BEQ,0,0,1,1, ex(0,1,0,0,1,1,0,2,0,2,2,0));
    add(BEQ,0,0,1,1, ex(1,0,0,0,0,0,0,0,1,1,2,0));
    add(BEQ,0,0,1,1, ex(10,0,0,0,0,1,0,0,2,0,2,1));
    // beq not taken
    add(BEQ,0,0,0,1, ex(0,1,0,0,1,1,0,2,0,2,2,0));
    add(BEQ,0,0,0,1, ex(1,0,0,0,0,0,0,0,1,1,2,0));
    add(BEQ,0,0,0,1, ex(10,0,0,0,0,0,0,0,2,0,2,1));
    // jal
    add(JAL,0,0,0,1, ex(0,1,0,0,1,1,0,2,0,2,3,0));
    add(JAL,0,0,0,1, ex(1,0,0,0,0,0,0,0,1,1,3,0));
    add(JAL,0,0,0,1, ex(9,0,0,0,0,1,0,0,1,2,3,0));
    add(JAL,0,0,0,1, ex(7,0,0,0,0,0,1,0,0,0,3,0));
`ifndef MULTICYCLE_CTRL_TRAP_EN
    // unknown opcode is a NOP: DECODE goes straight back to FETCH
    add(BAD,0,0,0,1, ex(0,1,0,0,1,1,0,2,0,2,0,0));
    add(BAD,0,0,0,1, ex(1,0,0,0,0,0,0,0,1,1,0,0));
`endif
    // lui
    add(LUI,0,0,0,1, ex(0,1,0,0,1,1,0,2,0,2,4,0));
    add(LUI,0,0,0,1, ex(1,0,0,0,0,0,0,0,1,1,4,0));
    add(LUI,0,0,0,1, ex(11,0,0,0,0,0,0,0,3,1,4,0));
    add(LUI,0,0,0,1, ex(7,0,0,0,0,0,1,0,0,0,4,0));

    // reset state: FETCH, strobes suppressed even with mem_ready=1
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_ir_write", 32'(ir_write), 32'd0);
    chk("rst_pc_write", 32'(pc_write), 32'd0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].z, tbl[i].rdy);
      #1;
      n_cmp++;
      if (actual() !== tbl[i].exp) begin
        n_fail++;
        $display("FAIL vec%0d: got 0x%06h, expected 0x%06h", i, actual(), tbl[i].exp);
      end
      @(negedge clk);
    end

`ifdef MULTICYCLE_CTRL_TRAP_EN
    // unknown opcode traps and stays trapped until reset
    drive(BAD, 3'd0, 1'b0, 1'b0, 1'b1);
    #1;
    chk("trap_fetch", 32'(state), 32'd0);
    @(negedge clk);
    #1;
    chk("trap_decode", 32'(state), 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      chk("trap_state", 32'(state), 32'd15);
      chk("trap_illegal", 32'(illegal_instr), 32'd1);
      chk("trap_enables", 32'({mem_req, mem_write, ir_write, pc_write, reg_write}), 32'd0);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("trap_cleared", 32'({state, illegal_instr}), 32'd0);
    @(negedge clk);
`endif

    // reset asserted in the middle of a stalled store
    drive(SW, 3'd2, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk("mw_state", 32'(state), 32'd5);
    chk("mw_strobe", 32'(mem_write), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_mem_write", 32'(mem_write), 32'd0);
    chk("abort_mem_req", 32'(mem_req), 32'd0);
    mem_ready = 1'b1;
    #1;
    chk("abort_ir_pc", 32'({ir_write, pc_write, reg_write}), 32'd0);
    @(negedge clk);
    #1;
    chk("held_state", 32'(state), 32'd0);
    reset = 1'b0;
    #1;
    chk("release_fetch", 32'({mem_req, ir_write, pc_write}), 32'b111);
    @(negedge clk);
    #1;
    chk("release_decode", 32'(state), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
